draw_player: RTL and testbench

- Overlay stage placed directly downstream of the background stage in the VGA pipeline.
- Takes the background-coloured VGA stream and paints a solid square player sprite over it.
- Moves the sprite once per frame from four direction inputs, clamped inside the playfield's inner border.
- Exports the current sprite position for later collision and game-logic stages.

---
 rtl/draw_player_if.sv | 20 ++
 rtl/draw_player.sv | 196 +++++++++++++++++++
 tb/tb_draw_player.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/draw_player_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_if
//  Description : VGA pixel-stream bundle (timing counters, syncs, blanking
//                flags and 12-bit RGB) passed between pipeline stages.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface
`default_nettype wire

// File: rtl/draw_player.sv
`default_nettype none
// ============================================================================
//  Module      : draw_player
//  Description : Paints a solid square player sprite over the background
//                VGA stream (1-cycle latency) and moves it once per movement
//                event, at the start of vertical blanking, from four level
//                direction buttons, clamped inside the playfield border.
//  Revision    : 1.0 - initial release
// ============================================================================
module draw_player #(
    parameter int          HOR_PIXELS = 1024,
    parameter int          VER_PIXELS = 768,
    parameter int          SIZE       = 16,
    parameter int          START_X    = 504,
    parameter int          START_Y    = 376,
    parameter int          STEP       = 2,
    parameter int          MOVE_DIV   = 1,
    parameter logic [11:0] COLOR      = 12'hff0,
    parameter int          X_MIN      = 6,
    parameter int          Y_MIN      = 6,
    parameter int          X_MAX      = HOR_PIXELS - 6 - SIZE,
    parameter int          Y_MAX      = VER_PIXELS - 6 - SIZE
) (
    input  logic        clk,
    input  logic        rst,
    vga_if.in           vga_in,
    vga_if.out          vga_out,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    output logic [10:0] pos_x,
    output logic [10:0] pos_y
);

    // Divider counter width; at least one bit even when MOVE_DIV is 1.
    localparam int              CW          = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [CW-1:0]   c_DIV_LAST  = CW'(MOVE_DIV - 1);

    // 12-bit versions are used for comparisons so sums never wrap;
    // 11-bit versions are the values actually written to the position.
    localparam logic [11:0]     c_SIZE12    = 12'(SIZE);
    localparam logic [11:0]     c_STEP12    = 12'(STEP);
    localparam logic [11:0]     c_XMIN12    = 12'(X_MIN);
    localparam logic [11:0]     c_XMAX12    = 12'(X_MAX);
    localparam logic [11:0]     c_YMIN12    = 12'(Y_MIN);
    localparam logic [11:0]     c_YMAX12    = 12'(Y_MAX);
    localparam logic [10:0]     c_STEP11    = 11'(STEP);
    localparam logic [10:0]     c_XMIN11    = 11'(X_MIN);
    localparam logic [10:0]     c_XMAX11    = 11'(X_MAX);
    localparam logic [10:0]     c_YMIN11    = 11'(Y_MIN);
    localparam logic [10:0]     c_YMAX11    = 11'(Y_MAX);
    localparam logic [10:0]     c_START_X   = 11'(START_X);
    localparam logic [10:0]     c_START_Y   = 11'(START_Y);

    localparam logic [0:0]      S_IDLE      = 1'b0;
    localparam logic [0:0]      S_STEP      = 1'b1;

    logic [10:0]    r_hcount;
    logic [10:0]    r_vcount;
    logic           r_hsync;
    logic           r_vsync;
    logic           r_hblnk;
    logic           r_vblnk;
    logic [11:0]    r_rgb;

    logic [10:0]    r_pos_x;
    logic [10:0]    r_pos_y;
    logic           r_vblnk_d;
    logic [CW-1:0]  r_div_cnt;
    logic [0:0]     r_state;
    logic [3:0]     r_dir;          // {up, down, left, right}

    logic           w_tick;
    logic           w_event;
    logic           w_in_rect;
    logic [11:0]    w_rgb;
    logic [11:0]    w_h12;
    logic [11:0]    w_v12;
    logic [11:0]    w_px12;
    logic [11:0]    w_py12;
    logic [10:0]    w_next_x;
    logic [10:0]    w_next_y;

    assign w_tick  = vga_in.vblnk & ~r_vblnk_d;
    assign w_event = w_tick && (r_div_cnt == c_DIV_LAST);

    assign w_h12   = {1'b0, vga_in.hcount};
    assign w_v12   = {1'b0, vga_in.vcount};
    assign w_px12  = {1'b0, r_pos_x};
    assign w_py12  = {1'b0, r_pos_y};

    // Sprite hit test against the current position, with blanking passthrough.
    always_comb begin
        w_in_rect = (w_h12 >= w_px12) && (w_h12 < w_px12 + c_SIZE12) &&
                    (w_v12 >= w_py12) && (w_v12 < w_py12 + c_SIZE12);
        if (vga_in.hblnk || vga_in.vblnk) begin
            w_rgb = vga_in.rgb;
        end else if (w_in_rect) begin
            w_rgb = COLOR;
        end else begin
            w_rgb = vga_in.rgb;
        end
    end

    // Next position from latched directions; clamp is decided before subtracting.
    always_comb begin
        w_next_x = r_pos_x;
        w_next_y = r_pos_y;
        if (r_dir[3] ^ r_dir[2]) begin
            if (r_dir[3]) begin
                w_next_y = (w_py12 < c_YMIN12 + c_STEP12) ? c_YMIN11 : r_pos_y - c_STEP11;
            end else begin
                w_next_y = (w_py12 + c_STEP12 > c_YMAX12) ? c_YMAX11 : r_pos_y + c_STEP11;
            end
        end
        if (r_dir[1] ^ r_dir[0]) begin
            if (r_dir[1]) begin
                w_next_x = (w_px12 < c_XMIN12 + c_STEP12) ? c_XMIN11 : r_pos_x - c_STEP11;
            end else begin
                w_next_x = (w_px12 + c_STEP12 > c_XMAX12) ? c_XMAX11 : r_pos_x + c_STEP11;
            end
        end
    end

    // One-cycle output pipeline: timing fields copied, rgb overlaid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcount <= '0;
            r_vcount <= '0;
            r_hsync  <= 1'b0;
            r_vsync  <= 1'b0;
            r_hblnk  <= 1'b0;
            r_vblnk  <= 1'b0;
            r_rgb    <= '0;
        end else begin
            r_hcount <= vga_in.hcount;
            r_vcount <= vga_in.vcount;
            r_hsync  <= vga_in.hsync;
            r_vsync  <= vga_in.vsync;
            r_hblnk  <= vga_in.hblnk;
            r_vblnk  <= vga_in.vblnk;
            r_rgb    <= w_rgb;
        end
    end

    // Frame tick edge detector and movement-rate divider.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vblnk_d <= 1'b0;
            r_div_cnt <= '0;
        end else begin
            r_vblnk_d <= vga_in.vblnk;
            if (w_tick) begin
                r_div_cnt <= (r_div_cnt == c_DIV_LAST) ? '0 : r_div_cnt + 1'b1;
            end
        end
    end

    // Movement FSM: latch buttons on the event, apply them in the single STEP cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_dir   <= '0;
            r_pos_x <= c_START_X;
            r_pos_y <= c_START_Y;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_event) begin
                        r_dir   <= {btn_up, btn_down, btn_left, btn_right};
                        r_state <= S_STEP;
                    end
                end
                S_STEP: begin
                    r_pos_x <= w_next_x;
                    r_pos_y <= w_next_y;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign vga_out.hcount = r_hcount;
    assign vga_out.vcount = r_vcount;
    assign vga_out.hsync  = r_hsync;
    assign vga_out.vsync  = r_vsync;
    assign vga_out.hblnk  = r_hblnk;
    assign vga_out.vblnk  = r_vblnk;
    assign vga_out.rgb    = r_rgb;
    assign pos_x          = r_pos_x;
    assign pos_y          = r_pos_y;

endmodule
`default_nettype wire

// File: tb/tb_draw_player.sv
`default_nettype none
// ============================================================================
//  Module      : tb_draw_player
//  Description : Self-checking bench for draw_player. Three instances share
//                one input stream: A (defaults), B (starts at x=7, y=Y_MAX)
//                and C (MOVE_DIV=4). Instance A's output stream is checked
//                through a scoreboard; positions are checked directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_draw_player;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic a_up = 0, a_dn = 0, a_lf = 0, a_rt = 0;
    logic b_up = 0, b_dn = 0, b_lf = 0, b_rt = 0;
    logic c_up = 0, c_dn = 0, c_lf = 0, c_rt = 0;
    logic [10:0] ax, ay, bx, by, cx, cy;

    int checks   = 0;
    int failures = 0;
    exp_t sb [$];
    int c_y_tab [8] = '{376, 376, 376, 378, 378, 378, 378, 380};

    vga_if vin ();
    vga_if voa ();
    vga_if vob ();
    vga_if voc ();

    draw_player u_a (
        .clk(clk), .rst(rst), .vga_in(vin), .vga_out(voa),
        .btn_up(a_up), .btn_down(a_dn), .btn_left(a_lf), .btn_right(a_rt),
        .pos_x(ax), .pos_y(ay)
    );

    draw_player #(.START_X(7), .START_Y(746)) u_b (
        .clk(clk), .rst(rst), .vga_in(vin), .vga_out(vob),
        .btn_up(b_up), .btn_down(b_dn), .btn_left(b_lf), .btn_right(b_rt),
        .pos_x(bx), .pos_y(by)
    );

    draw_player #(.MOVE_DIV(4)) u_c (
        .clk(clk), .rst(rst), .vga_in(vin), .vga_out(voc),
        .btn_up(c_up), .btn_down(c_dn), .btn_left(c_lf), .btn_right(c_rt),
        .pos_x(cx), .pos_y(cy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: compare A's output against the oldest expectation, then drive
    // the next input pixel and push what A must produce for it one cycle later.
    task automatic drive(input logic r, input logic [10:0] h, input logic [10:0] v,
                         input logic hs, input logic vs, input logic hb, input logic vb,
                         input logic [11:0] rgb, input logic [11:0] exp_rgb);
        exp_t e;
        exp_t got;
        @(negedge clk);
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            got = '{voa.hcount, voa.vcount, voa.hsync, voa.vsync, voa.hblnk, voa.vblnk, voa.rgb};
            chk("vga_out", 64'(got), 64'(e));
        end
        rst        = r;
        vin.hcount = h;
        vin.vcount = v;
        vin.hsync  = hs;
        vin.vsync  = vs;
        vin.hblnk  = hb;
        vin.vblnk  = vb;
        vin.rgb    = rgb;
        if (r) e = '0;
        else   e = '{h, v, hs, vs, hb, vb, exp_rgb};
        sb.push_back(e);
    endtask

    // One short frame: 4 active cycles then 6 vblank cycles. Instance A must
    // hold (x0,y0) until exactly 2 cycles after vblnk rises, then show (x1,y1).
    task automatic frame(input logic [10:0] x0, input logic [10:0] y0,
                         input logic [10:0] x1, input logic [10:0] y1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 11'(i), 11'd0, i[0], 1'b0, i[1], 1'b0, 12'h100 + 12'(i), 12'h100 + 12'(i));
        end
        chk("A pos active", 64'({ax, ay}), 64'({x0, y0}));
        // Sprite coordinates during vblank must still pass the background through.
        drive(1'b0, 11'd504, 11'd376, 1'b0, 1'b1, 1'b0, 1'b1, 12'h2a5, 12'h2a5);
        drive(1'b0, 11'd505, 11'd377, 1'b0, 1'b1, 1'b1, 1'b1, 12'h2a6, 12'h2a6);
        chk("A pos tick+1", 64'({ax, ay}), 64'({x0, y0}));
        drive(1'b0, 11'd506, 11'd378, 1'b1, 1'b1, 1'b1, 1'b1, 12'h2a7, 12'h2a7);
        chk("A pos tick+2", 64'({ax, ay}), 64'({x1, y1}));
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 11'd0, 11'd770, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, 12'h000);
        end
    endtask

    initial begin
        vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
        vin.hblnk  = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;

        // Reset with busy inputs: outputs zero, positions at start.
        drive(1'b1, 11'd5, 11'd9, 1'b1, 1'b1, 1'b1, 1'b0, 12'habc, 12'habc);
        drive(1'b1, 11'd6, 11'd9, 1'b1, 1'b0, 1'b1, 1'b0, 12'habd, 12'habd);
        chk("A reset pos", 64'({ax, ay}), 64'({11'd504, 11'd376}));
        chk("B reset pos", 64'({bx, by}), 64'({11'd7, 11'd746}));

        // Two idle frames: position holds.
        frame(11'd504, 11'd376, 11'd504, 11'd376);
        frame(11'd504, 11'd376, 11'd504, 11'd376);

        // Pixel rule around the sprite rectangle.
        drive(1'b0, 11'd504, 11'd376, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0a1, 12'hff0);
        drive(1'b0, 11'd519, 11'd391, 1'b0, 1'b1, 1'b0, 1'b0, 12'h0a2, 12'hff0);
        drive(1'b0, 11'd503, 11'd376, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0a3, 12'h0a3);
        drive(1'b0, 11'd520, 11'd376, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0a4, 12'h0a4);
        drive(1'b0, 11'd504, 11'd392, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0a5, 12'h0a5);
        drive(1'b0, 11'd519, 11'd375, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0a6, 12'h0a6);
        drive(1'b0, 11'd510, 11'd380, 1'b0, 1'b0, 1'b1, 1'b0, 12'h0a7, 12'h0a7);
        drive(1'b0, 11'd511, 11'd381, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0a8, 12'hff0);

        // A moves right each frame; B clamps at X_MIN and Y_MAX.
        a_rt = 1'b1;
        b_lf = 1'b1;
        b_dn = 1'b1;
        frame(11'd504, 11'd376, 11'd506, 11'd376);
        chk("B left clamp f1", 64'({bx, by}), 64'({11'd6, 11'd746}));
        frame(11'd506, 11'd376, 11'd508, 11'd376);
        chk("B left clamp f2", 64'({bx, by}), 64'({11'd6, 11'd746}));
        frame(11'd508, 11'd376, 11'd510, 11'd376);
        chk("B left clamp f3", 64'({bx, by}), 64'({11'd6, 11'd746}));

        // Opposing vertical buttons cancel; up+left is one diagonal step.
        a_rt = 1'b0;
        a_up = 1'b1;
        a_dn = 1'b1;
        frame(11'd510, 11'd376, 11'd510, 11'd376);
        a_dn = 1'b0;
        a_lf = 1'b1;
        frame(11'd510, 11'd376, 11'd508, 11'd374);
        a_up = 1'b0;
        a_lf = 1'b0;

        // Fresh reset, then MOVE_DIV=4 moves C only on every fourth frame.
        drive(1'b1, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000);
        drive(1'b1, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000);
        chk("A pos after reset", 64'({ax, ay}), 64'({11'd504, 11'd376}));
        chk("C pos after reset", 64'({cx, cy}), 64'({11'd504, 11'd376}));
        c_dn = 1'b1;
        for (int f = 0; f < 8; f++) begin
            frame(11'd504, 11'd376, 11'd504, 11'd376);
            chk($sformatf("C div frame %0d", f + 1), 64'({cx, cy}), 64'({11'd504, 11'(c_y_tab[f])}));
        end
        c_dn = 1'b0;

        // Reset during STEP discards the pending move.
        a_rt = 1'b1;
        frame(11'd504, 11'd376, 11'd506, 11'd376);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 11'(i + 20), 11'd5, 1'b1, 1'b0, 1'b0, 1'b0, 12'h3c0, 12'h3c0);
        end
        drive(1'b0, 11'd30, 11'd770, 1'b0, 1'b1, 1'b1, 1'b1, 12'h3c1, 12'h3c1);
        drive(1'b1, 11'd31, 11'd770, 1'b0, 1'b1, 1'b1, 1'b1, 12'h3c2, 12'h3c2);
        chk("A pos in STEP", 64'({ax, ay}), 64'({11'd506, 11'd376}));
        drive(1'b0, 11'd40, 11'd41, 1'b1, 1'b1, 1'b0, 1'b0, 12'h3c3, 12'h3c3);
        chk("A pos rst in STEP", 64'({ax, ay}), 64'({11'd504, 11'd376}));
        drive(1'b0, 11'd42, 11'd43, 1'b0, 1'b1, 1'b1, 1'b0, 12'h3c4, 12'h3c4);
        chk("A pos after rst", 64'({ax, ay}), 64'({11'd504, 11'd376}));
        a_rt = 1'b0;
        drive(1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000);
        drive(1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
